// File: rtl/sprite_pkg.sv
// Shared sprite constants, slot record layout and wr_data field offsets.
// Used by sprite_addr_gen and sprite_hit_detect.
package sprite_pkg;

  localparam int SPRITE_SIZE   = 16;
  localparam int SHEET_TILES   = 496;
  localparam int TILES_PER_ROW = 16;
  localparam int COL_W         = $clog2(TILES_PER_ROW);

  localparam int WR_EN_BIT   = 31;
  localparam int WR_FRM_LSB  = 29;
  localparam int WR_X_LSB    = 19;
  localparam int WR_Y_LSB    = 9;
  localparam int WR_TILE_LSB = 0;

  typedef struct packed {
    logic       en;
    logic [1:0] frames;
    logic [9:0] x;
    logic [9:0] y;
    logic [8:0] tile;
  } slot_t;

  function automatic slot_t unpack_slot(input logic [31:0] d);
    slot_t s;
    s.en     = d[WR_EN_BIT];
    s.frames = d[WR_FRM_LSB +: 2];
    s.x      = d[WR_X_LSB +: 10];
    s.y      = d[WR_Y_LSB +: 10];
    s.tile   = d[WR_TILE_LSB +: 9];
    return s;
  endfunction

  // frames==3 animates like frames==2 (four-phase cycle)
  function automatic logic [1:0] frame_mask(input logic [1:0] frames);
    logic [1:0] m;
    unique case (frames)
      2'd0:    m = 2'd0;
      2'd1:    m = 2'd1;
      default: m = 2'd3;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sprite_addr_gen_if.sv
// Slot-write / frame-sync bus feeding sprite_addr_gen.
// master drives writes and frame_start, slave receives them.
interface sprite_addr_gen_if;
  logic        frame_start;
  logic        wr_en;
  logic [2:0]  wr_slot;
  logic [31:0] wr_data;

  modport master (
    output frame_start, wr_en, wr_slot, wr_data
  );
  modport slave (
    input frame_start, wr_en, wr_slot, wr_data
  );
endinterface

// File: rtl/sprite_hit_detect.sv
// Per-slot hit test and sprite-sheet address for the current pixel.
// Compares run 11 bits wide so a sprite near column 1023 never wraps.
module sprite_hit_detect
  import sprite_pkg::*;
(
  input  slot_t       slot,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [1:0]  phase,
  output logic        hit,
  output logic [16:0] addr
);

  logic [10:0] px, py, sx, sy;
  logic [3:0]  dx, dy;
  logic [9:0]  tile;
  logic        in_x, in_y;

  always_comb begin
    px   = {1'b0, draw_x};
    py   = {1'b0, draw_y};
    sx   = {1'b0, slot.x};
    sy   = {1'b0, slot.y};
    dx   = draw_x[3:0] - slot.x[3:0];
    dy   = draw_y[3:0] - slot.y[3:0];
    in_x = (px >= sx) && (px < sx + 11'(SPRITE_SIZE));
    in_y = (py >= sy) && (py < sy + 11'(SPRITE_SIZE));
    tile = {1'b0, slot.tile}
         + {8'b0, phase & frame_mask(slot.frames)};
    hit  = slot.en && in_x && in_y
        && (tile < 10'(SHEET_TILES));
    addr = {tile[8:COL_W], dy, tile[COL_W-1:0], dx};
  end

endmodule

// File: rtl/sprite_addr_gen.sv
// Sprite slot table with shadow/active copies and two-hit address output.
// Define SPRITE_ANIM_EN to enable frame-counted animation phase.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int ANIM_DIV  = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic        wr_en,
  input  logic [2:0]  wr_slot,
  input  logic [31:0] wr_data,
  output logic [16:0] read_address,
  output logic [16:0] read_address2,
  output logic        hit_valid,
  output logic        hit_valid2
);

  if (NUM_SLOTS < 2 || NUM_SLOTS > 8 ||
      ANIM_DIV < 1 || ANIM_DIV > 255) begin : g_bad_cfg
    $error("sprite_addr_gen: parameter out of range");
  end

  slot_t       shadow_q [NUM_SLOTS];
  slot_t       shadow_d [NUM_SLOTS];
  slot_t       active_q [NUM_SLOTS];
  slot_t       active_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit;
  logic [16:0] addr [NUM_SLOTS];
  logic [1:0]  phase;

  logic [16:0] addr1_d, addr1_q;
  logic [16:0] addr2_d, addr2_q;
  logic        hv1_d, hv1_p_q, hv1_q;
  logic        hv2_d, hv2_p_q, hv2_q;

`ifdef SPRITE_ANIM_EN
  logic [7:0] fcnt_d, fcnt_q;
  logic [1:0] phase_d, phase_q;

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (fcnt_q == 8'(ANIM_DIV - 1)) begin
        fcnt_d  = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        fcnt_d  = fcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fcnt_q  <= '0;
      phase_q <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
`else
  assign phase = 2'd0;
`endif

  // Commit reads the pre-write shadow; a same-cycle write waits a frame
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (frame_start) active_d = shadow_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (wr_en && wr_slot == 3'(i))
        shadow_d[i] = unpack_slot(wr_data);
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    sprite_hit_detect u_hit (
      .slot   (active_q[g]),
      .draw_x (DrawX),
      .draw_y (DrawY),
      .phase  (phase),
      .hit    (hit[g]),
      .addr   (addr[g])
    );
  end

  always_comb begin
    hv1_d   = 1'b0;
    hv2_d   = 1'b0;
    addr1_d = '0;
    addr2_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (hit[i] && !hv1_d) begin
        hv1_d   = 1'b1;
        addr1_d = addr[i];
      end else if (hit[i] && !hv2_d) begin
        hv2_d   = 1'b1;
        addr2_d = addr[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      addr1_q <= '0;
      addr2_q <= '0;
      hv1_p_q <= 1'b0;
      hv2_p_q <= 1'b0;
      hv1_q   <= 1'b0;
      hv2_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      hv1_p_q  <= hv1_d;
      hv2_p_q  <= hv2_d;
      hv1_q    <= hv1_p_q;
      hv2_q    <= hv2_p_q;
    end
  end

  assign read_address  = addr1_q;
  assign read_address2 = addr2_q;
  assign hit_valid     = hv1_q;
  assign hit_valid2    = hv2_q;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Self-checking bench for sprite_addr_gen (NUM_SLOTS=7, ANIM_DIV=2).
// Animation checks compile in only with SPRITE_ANIM_EN.
module tb_sprite_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  draw_x, draw_y;
  logic [16:0] ra1, ra2;
  logic        hv1, hv2;

  sprite_addr_gen_if wif();

  always #5 clk = ~clk;

  sprite_addr_gen #(
    .NUM_SLOTS (7),
    .ANIM_DIV  (2)
  ) dut (
    .Clk           (clk),
    .Reset         (rst),
    .DrawX         (draw_x),
    .DrawY         (draw_y),
    .frame_start   (wif.frame_start),
    .wr_en         (wif.wr_en),
    .wr_slot       (wif.wr_slot),
    .wr_data       (wif.wr_data),
    .read_address  (ra1),
    .read_address2 (ra2),
    .hit_valid     (hv1),
    .hit_valid2    (hv2)
  );

  typedef struct {
    logic        rst;
    logic [16:0] a1;
    logic [16:0] a2;
    logic        v1;
    logic        v2;
  } exp_t;

  typedef struct {
    int   x;
    int   y;
    int   a1;
    int   a2;
    logic v1;
    logic v2;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur, prev;
  bit   prev_ok = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, req);
    end
  endtask

  // Addresses belong to the previous cycle's pixel, valids to the one before
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("read_address", ra1, cur.a1);
      chk("read_address2", ra2, cur.a2);
      chk("hit_valid", hv1,
          (cur.rst || !prev_ok) ? 1'b0 : prev.v1);
      chk("hit_valid2", hv2,
          (cur.rst || !prev_ok) ? 1'b0 : prev.v2);
      prev    = cur;
      prev_ok = 1'b1;
    end
  end

  function automatic logic [31:0] mk(
    input logic en, input logic [1:0] fr,
    input logic [9:0] x, input logic [9:0] y,
    input logic [8:0] t);
    return {en, fr, x, y, t};
  endfunction

  task automatic cyc(
    input logic r, input logic fs, input logic we,
    input logic [2:0] ws, input logic [31:0] wd,
    input int x, input int y, input int a1, input int a2,
    input logic v1, input logic v2);
    exp_t e;
    @(negedge clk);
    rst             = r;
    wif.frame_start = fs;
    wif.wr_en       = we;
    wif.wr_slot     = ws;
    wif.wr_data     = wd;
    draw_x          = 10'(x);
    draw_y          = 10'(y);
    e.rst = r;
    e.a1  = r ? 17'd0 : 17'(a1);
    e.a2  = r ? 17'd0 : 17'(a2);
    e.v1  = r ? 1'b0 : v1;
    e.v2  = r ? 1'b0 : v2;
    exp_q.push_back(e);
  endtask

  task automatic px(input int x, input int y,
                    input int a1, input int a2,
                    input logic v1, input logic v2);
    cyc(0, 0, 0, 0, 0, x, y, a1, a2, v1, v2);
  endtask

  task automatic wr(input logic [2:0] s,
                    input logic [31:0] d);
    cyc(0, 0, 1, s, d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fsync();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_cyc();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{103,  54,   9299,   0, 1'b1, 1'b0};
    tbl[1]  = '{200, 200,   2586, 549, 1'b1, 1'b1};
    tbl[2]  = '{ 99,  54,      0,   0, 1'b0, 1'b0};
    tbl[3]  = '{115,  65,  12127,   0, 1'b1, 1'b0};
    tbl[4]  = '{116,  54,      0,   0, 1'b0, 1'b0};
    tbl[5]  = '{103,  66,      0,   0, 1'b0, 1'b0};
    tbl[6]  = '{  3,  12,      0,   0, 1'b0, 1'b0};
    tbl[7]  = '{1020, 12,    565,   0, 1'b1, 1'b0};
    tbl[8]  = '{305, 305,      0,   0, 1'b0, 1'b0};
    tbl[9]  = '{405, 401, 123381,   0, 1'b1, 1'b0};
    tbl[10] = '{505, 505,      0,   0, 1'b0, 1'b0};
    tbl[11] = '{192, 199,   2322,   0, 1'b1, 1'b0};
    tbl[12] = '{197, 199,   2327, 290, 1'b1, 1'b1};

    rst             = 1'b1;
    draw_x          = '0;
    draw_y          = '0;
    wif.frame_start = 1'b0;
    wif.wr_en       = 1'b0;
    wif.wr_slot     = '0;
    wif.wr_data     = '0;

    reset_cyc();
    reset_cyc();

    wr(0, mk(1, 0,  100,  50,  37));
    wr(1, mk(1, 0,  190, 190,   1));
    wr(2, mk(1, 0,  195, 198,   2));
    wr(5, mk(1, 0,  200, 200,   5));
    wr(3, mk(1, 0, 1015,  10,   3));
    wr(4, mk(1, 0,  300, 300, 496));
    wr(6, mk(1, 2,  400, 400, 495));
    wr(7, mk(1, 0,  500, 500,   7));
    px(103, 54, 0, 0, 0, 0);
    fsync();

    for (int i = 0; i < 13; i++)
      px(tbl[i].x, tbl[i].y, tbl[i].a1, tbl[i].a2,
         tbl[i].v1, tbl[i].v2);

    // shadow write vs commit timing
    wr(0, mk(1, 0, 300, 50, 37));
    px(103, 54, 9299, 0, 1, 0);
    fsync();
    px(103, 54, 0, 0, 0, 0);
    px(303, 54, 9299, 0, 1, 0);
    cyc(0, 1, 1, 0, mk(1, 0, 100, 50, 37),
        0, 0, 0, 0, 0, 0);
    px(303, 54, 9299, 0, 1, 0);
    px(103, 54, 0, 0, 0, 0);
    fsync();
    px(103, 54, 9299, 0, 1, 0);
    px(303, 54, 0, 0, 0, 0);

    // reset mid-frame beats a coincident write and commit
    px(103, 54, 9299, 0, 1, 0);
    cyc(1, 1, 1, 0, mk(1, 0, 500, 500, 1),
        103, 54, 0, 0, 0, 0);
    px(103, 54, 0, 0, 0, 0);
    fsync();
    px(505, 505, 0, 0, 0, 0);
    px(103, 54, 0, 0, 0, 0);

`ifdef SPRITE_ANIM_EN
    reset_cyc();
    wr(0, mk(1, 1, 100,  50,  10));
    wr(1, mk(1, 2, 200, 200, 495));
    fsync();
    px(103, 54, 1187, 0, 1, 0);
    px(205, 205, 124405, 0, 1, 0);
    fsync();
    px(103, 54, 1203, 0, 1, 0);
    px(205, 205, 0, 0, 0, 0);
    fsync();
    fsync();
    px(103, 54, 1187, 0, 1, 0);
`endif

    repeat (3) px(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0",
               exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
